// File: rtl/decode_stage.sv
// RISC-V decode pipeline stage: field/immediate split with a 2-entry skid buffer.
// Optional illegal-instruction checking is enabled by defining DECODE_ILLEGAL_CHECK_EN.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [5:0]      out_type,
  output logic            out_illegal
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_IMMW = 7'b0011011;
  localparam logic [6:0] OP_RW   = 7'b0111011;

  localparam logic [5:0] T_R = 6'b000001;
  localparam logic [5:0] T_I = 6'b000010;
  localparam logic [5:0] T_S = 6'b000100;
  localparam logic [5:0] T_B = 6'b001000;
  localparam logic [5:0] T_U = 6'b010000;
  localparam logic [5:0] T_J = 6'b100000;

  typedef struct packed {
    logic [PC_W-1:0]        pc;
    logic [31:0]            instr;
    logic signed [XLEN-1:0] imm;
    logic [5:0]             typ;
    logic                   illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  function automatic entry_t decode(input logic [31:0] instr, input logic [PC_W-1:0] pc);
    entry_t           d;
    logic [6:0]       op;
    logic signed [31:0] imm32;
`ifdef DECODE_ILLEGAL_CHECK_EN
    logic [2:0]       f3;
`endif
    op        = instr[6:0];
    d.pc      = pc;
    d.instr   = instr;
    d.typ     = '0;
    d.illegal = 1'b0;
    imm32     = '0;
    case (op)
      OP_R:                      d.typ = T_R;
      OP_IMM, OP_LOAD, OP_JALR:  d.typ = T_I;
      OP_ST:                     d.typ = T_S;
      OP_BR:                     d.typ = T_B;
      OP_LUI, OP_AUI:            d.typ = T_U;
      OP_JAL:                    d.typ = T_J;
      OP_IMMW:                   if (XLEN == 64) d.typ = T_I;
      OP_RW:                     if (XLEN == 64) d.typ = T_R;
      default:                   d.typ = '0;
    endcase
`ifdef DECODE_ILLEGAL_CHECK_EN
    f3 = instr[14:12];
    // unknown opcodes (including instr[1:0] != 11) leave typ at zero
    d.illegal = (instr[1:0] != 2'b11) || (d.typ == '0)
             || (op == OP_BR   && (f3 == 3'b010 || f3 == 3'b011))
             || (op == OP_JALR && f3 != 3'b000)
             || (op == OP_LOAD && (f3 == 3'b111 || (XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110))))
             || (op == OP_ST   && (f3[2] || (XLEN == 32 && f3 == 3'b011)));
    if (d.illegal) d.typ = '0;
`endif
    case (d.typ)
      T_I:     imm32 = {{20{instr[31]}}, instr[31:20]};
      T_S:     imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      T_B:     imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      T_U:     imm32 = {instr[31:12], 12'b0};
      T_J:     imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    d.imm = XLEN'(imm32);
    return d;
  endfunction

  entry_t dec_p0, out_p1, skid_p1;
  state_t state;
  logic   accept, drain;

  // stage 0: combinational decode of the presented instruction
  assign dec_p0 = decode(in_instr, in_pc);
  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // stage 1: output register plus skid entry, in_ready registered from state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_p1    <= '0;
      skid_p1   <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          out_p1    <= dec_p0;
          out_valid <= 1'b1;
          state     <= ONE;
        end
        ONE: begin
          if (accept && drain) begin
            out_p1 <= dec_p0;
          end else if (accept) begin
            skid_p1  <= dec_p0;
            state    <= TWO;
            in_ready <= 1'b0;
          end else if (drain) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        TWO: if (drain) begin
          out_p1   <= skid_p1;
          state    <= ONE;
          in_ready <= 1'b1;
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_pc      = out_p1.pc;
  assign out_opcode  = out_p1.instr[6:0];
  assign out_rd      = out_p1.instr[11:7];
  assign out_funct3  = out_p1.instr[14:12];
  assign out_rs1     = out_p1.instr[19:15];
  assign out_rs2     = out_p1.instr[24:20];
  assign out_funct7  = out_p1.instr[31:25];
  assign out_imm     = out_p1.imm;
  assign out_type    = out_p1.typ;
  assign out_illegal = out_p1.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: vector table fed through a queue scoreboard plus stall/flush sequences.
module tb_decode_stage;
  localparam int XLEN = 32;
  localparam int PC_W = 32;
`ifdef DECODE_ILLEGAL_CHECK_EN
  localparam bit ILL = 1'b1;
`else
  localparam bit ILL = 1'b0;
`endif
  localparam bit X64 = (XLEN == 64);

  logic            clk = 1'b0;
  logic            rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [6:0]      out_opcode, out_funct7;
  logic [4:0]      out_rd, out_rs1, out_rs2;
  logic [2:0]      out_funct3;
  logic [XLEN-1:0] out_imm;
  logic [5:0]      out_type;
  logic            out_illegal;

  decode_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct7(out_funct7),
    .out_imm(out_imm), .out_type(out_type), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [63:0] imm;
    logic [5:0]  typ;
    logic        ill;
  } exp_t;

  exp_t vec[16];
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic [31:0] pc_ctr = 32'h1000;

  function automatic exp_t mk(logic [31:0] ins, logic [63:0] imm, logic [5:0] typ, bit bad);
    exp_t e;
    e.instr = ins;
    e.pc    = '0;
    e.ill   = ILL && bad;
    e.imm   = e.ill ? 64'd0 : imm;
    e.typ   = e.ill ? 6'd0 : typ;
    return e;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // One cycle: drive inputs on the falling edge, check outputs against the model, update it.
  task automatic tick(input logic iv, input int idx, input logic ordy, input logic fl, output bit acc);
    bit   mrdy;
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    in_instr  = vec[idx].instr;
    in_pc     = pc_ctr;
    out_ready = ordy;
    flush     = fl;
    mrdy = (q.size() < 2);
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(mrdy));
    if (q.size() != 0) begin
      e = q[0];
      chk("pc", 64'(out_pc), 64'(e.pc));
      chk("fields", 64'({out_funct7, out_rs2, out_rs1, out_funct3, out_rd, out_opcode}), 64'(e.instr));
      chk("imm", 64'(out_imm), 64'(e.imm[XLEN-1:0]));
      chk("type", 64'(out_type), 64'(e.typ));
      chk("illegal", 64'(out_illegal), 64'(e.ill));
    end
    acc = iv && mrdy && !fl;
    if (fl) begin
      q.delete();
    end else begin
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (acc) begin
        e = vec[idx];
        e.pc = pc_ctr;
        q.push_back(e);
      end
    end
    if (acc || (fl && iv)) pc_ctr = pc_ctr + 32'd4;
  endtask

  // Present vec[idx] until accepted; out_ready follows stall budget.
  task automatic send(input int idx, input logic ordy);
    bit acc;
    int guard = 0;
    acc = 1'b0;
    while (!acc && guard < 20) begin
      tick(1'b1, idx, ordy, 1'b0, acc);
      guard++;
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    bit acc;
    int stall;
    vec[0]  = mk(32'hFFF10093, 64'hFFFF_FFFF_FFFF_FFFF, 6'b000010, 1'b0);
    vec[1]  = mk(32'h00512423, 64'h8,                   6'b000100, 1'b0);
    vec[2]  = mk(32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 6'b001000, 1'b0);
    vec[3]  = mk(32'h123450B7, 64'h1234_5000,           6'b010000, 1'b0);
    vec[4]  = mk(32'h001000EF, 64'h800,                 6'b100000, 1'b0);
    vec[5]  = mk(32'h002081B3, 64'h0,                   6'b000001, 1'b0);
    vec[6]  = mk(32'hFFFFF117, 64'hFFFF_FFFF_FFFF_F000, 6'b010000, 1'b0);
    vec[7]  = mk(32'h00412083, 64'h4,                   6'b000010, 1'b0);
    vec[8]  = mk(32'h00000000, 64'h0,                   6'b000000, 1'b1);
    vec[9]  = mk(32'h00002067, 64'h0,                   6'b000010, 1'b1);
    vec[10] = X64 ? mk(32'h0010009B, 64'h1, 6'b000010, 1'b0)
                  : mk(32'h0010009B, 64'h0, 6'b000000, 1'b1);
    vec[11] = mk(32'h00113423, 64'h8, 6'b000100, !X64);
    vec[12] = mk(32'h80000063, 64'hFFFF_FFFF_FFFF_F000, 6'b001000, 1'b0);
    vec[13] = mk(32'h8000006F, 64'hFFFF_FFFF_FFF0_0000, 6'b100000, 1'b0);
    vec[14] = mk(32'h7FF00013, 64'h7FF,                 6'b000010, 1'b0);
    vec[15] = mk(32'h00000001, 64'h0,                   6'b000000, 1'b1);

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_imm", 64'(out_imm), 64'd0);
    chk("rst_type", 64'(out_type), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_illegal", 64'(out_illegal), 64'd0);
    rst = 1'b0;

    // single addi, then back-to-back stream with no backpressure
    send(0, 1'b1);
    tick(1'b0, 0, 1'b1, 1'b0, acc);
    tick(1'b0, 0, 1'b1, 1'b0, acc);
    for (int i = 0; i < 16; i++) send(i, 1'b1);
    repeat (2) tick(1'b0, 0, 1'b1, 1'b0, acc);

    // jal with out_ready low for 3 cycles while input stays valid
    stall = 3;
    for (int i = 4; i < 8; i++) begin
      acc = 1'b0;
      for (int g = 0; g < 20 && !acc; g++) begin
        tick(1'b1, i, (stall == 0), 1'b0, acc);
        if (stall > 0) stall--;
      end
    end
    repeat (4) tick(1'b0, 0, 1'b1, 1'b0, acc);

    // fill to two entries, then flush with a same-cycle instruction
    send(1, 1'b0);
    send(2, 1'b0);
    tick(1'b1, 3, 1'b0, 1'b0, acc);
    tick(1'b1, 3, 1'b1, 1'b1, acc);
    tick(1'b0, 0, 1'b1, 1'b0, acc);
    chk("flush_queue_empty", 64'(q.size()), 64'd0);
    send(7, 1'b1);
    repeat (2) tick(1'b0, 0, 1'b1, 1'b0, acc);

    // random valid/ready mix over the whole table
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 16; i++) begin
        acc = 1'b0;
        for (int g = 0; g < 40 && !acc; g++)
          tick(($urandom_range(0, 3) != 0), i, ($urandom_range(0, 2) != 0), 1'b0, acc);
        if (!acc) chk("random_accept_timeout", 64'd0, 64'd1);
      end
    end

    for (int g = 0; g < 50 && q.size() != 0; g++) tick(1'b0, 0, 1'b1, 1'b0, acc);
    chk("drain_empty", 64'(q.size()), 64'd0);
    tick(1'b0, 0, 1'b1, 1'b0, acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered, parametrised RISC-V decode pipeline stage sitting between fetch and execute. Accepts an instruction and PC over a valid/ready handshake and splits out the register, funct and immediate fields plus a one-hot format type. Immediates are sign-extended to XLEN. Adds RV64 opcode support, illegal-instruction flagging, flush, and a 2-entry skid buffer so backpressure never drops or duplicates an instruction.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; sets immediate width and enables RV64 opcodes when 64.
PC_W, 32, width of the PC carried alongside the instruction.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept an instruction
in_instr  in  32  raw instruction word
in_pc  in  PC_W  PC of in_instr
flush  in  1  discard all held instructions
out_valid  out  1  decoded entry valid
out_ready  in  1  downstream accepts entry
out_pc  out  PC_W  PC of the decoded entry
out_opcode  out  7  instr[6:0]
out_rd  out  5  instr[11:7]
out_funct3  out  3  instr[14:12]
out_rs1  out  5  instr[19:15]
out_rs2  out  5  instr[24:20]
out_funct7  out  7  instr[31:25]
out_imm  out  XLEN  sign-extended immediate; 0 for R-type or unknown
out_type  out  6  one-hot {j,u,b,s,i,r}; all zero if unknown
out_illegal  out  1  instruction is illegal

Behaviour:
- Single clock `clk`; reset `rst` is synchronous and active-high.
- Reset: out_valid=0, in_ready=1, all out_* data fields=0, internal skid entry invalid.
- Decode is combinational on in_instr. Decoded results are captured into the output register or the skid register.
- Latency: an instruction accepted in cycle N appears on out_* in cycle N+1 when the stage was empty.
- States: EMPTY (no entries), ONE (output register valid), TWO (output register and skid register valid).
- Transfers: accept = in_valid & in_ready; drain = out_valid & out_ready.
- EMPTY, accept -> ONE.
- ONE, accept & !drain -> TWO; the new instruction goes into the skid register.
- ONE, accept & drain -> ONE; the output register loads the new instruction.
- ONE, drain only -> EMPTY.
- TWO, drain -> ONE; the skid entry moves to the output register.
- in_ready = (state != TWO); it is registered and does not depend combinationally on out_ready.
- Entries stay in order. out_* is stable while out_valid=1 and out_ready=0.
- flush: next state EMPTY and out_valid=0. An instruction presented in the same cycle as flush is dropped. flush has priority over accept and drain. Reset has priority over flush.
- Opcode to type mapping:
  - 0110011 -> r.
  - 0010011, 0000011, 1100111 -> i.
  - 0100011 -> s.
  - 1100011 -> b.
  - 0110111, 0010111 -> u.
  - 1101111 -> j.
  - When XLEN=64, 0011011 -> i and 0111011 -> r.
- Immediates, sign bit instr[31], extended to XLEN:
  - I: instr[31:20].
  - S: instr[31:25], instr[11:7].
  - B: instr[31], instr[7], instr[30:25], instr[11:8], 0.
  - U: instr[31:12] followed by 12 zeros, then sign-extended to XLEN.
  - J: instr[31], instr[19:12], instr[20], instr[30:21], 0.

Optional Feature:
Macro DECODE_ILLEGAL_CHECK_EN.
- Defined: out_illegal=1 when any of the following holds:
  - instr[1:0] != 11.
  - Opcode is not in the mapping above.
  - B-type with funct3 of 010 or 011.
  - JALR with funct3 != 000.
  - Load with funct3 of 111, or of 011/110 when XLEN=32.
  - Store with funct3 >= 100, or of 011 when XLEN=32.
- An illegal entry still flows through the handshake normally, with out_imm=0 and out_type=0.
- Not defined: out_illegal is tied to 0, unknown opcodes give out_type=0 and out_imm=0, and no funct3 checking is done.

Test Plan:
- Reset, then in_instr=0xFFF10093 (addi x1,x2,-1) -> next cycle out_type=000010, out_rd=1, out_rs1=2, out_imm=0xFFFFFFFF (XLEN=64: 0xFFFFFFFFFFFFFFFF).
- Back-to-back 0x00512423 (sw x5,8(x2)), 0xFE000EE3 (beq -4), 0x123450B7 (lui) -> out_imm sequence 0x8, 0xFFFFFFFC, 0x12345000; out_type 000100, 001000, 010000.
- 0x001000EF (jal x1,2048) with out_ready=0 for 3 cycles while in_valid stays 1 -> in_ready drops after the 2nd accept; no loss; after release outputs appear in order with jal imm=0x800.
- Flush while in TWO, with in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, flushed and same-cycle instructions never appear.
- With DECODE_ILLEGAL_CHECK_EN, 0x00000000 and 0x00002067 (JALR funct3=010) -> out_illegal=1, out_type=0. Without the macro -> out_illegal=0.
- XLEN=32 vs 64 with 0x0010009B (addiw) -> XLEN=64 gives out_type=000010, imm=1; XLEN=32 gives out_type=0 (and illegal=1 with the macro).
